// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_iter
//  Purpose  : Iterative signed/unsigned multiply/divide unit for the E stage.
//             Multiply retires MUL_BITS multiplier bits per cycle (shift-add);
//             divide is restoring, one quotient bit per cycle. Works on
//             operand magnitudes and applies sign correction on the last step.
//  Option   : MULDIV_EARLY_TERM_EN - end a multiply as soon as the remaining
//             multiplier magnitude becomes zero.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  // WIDTH must be a multiple of MUL_BITS; the multiply count below relies on it.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / MUL_BITS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_p_q, neg_p_d;   // product / quotient negative
  logic                 neg_r_q, neg_r_d;   // remainder negative
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // product, or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]     opb_q, opb_d;       // remaining multiplier, or divisor
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 valid_q, valid_d;
  logic                 dbz_q, dbz_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   pp, mul_acc, mcand_shift, mul_res;
  logic [WIDTH-1:0]     mplier_shift;
  logic                 mul_last;
  logic [WIDTH:0]       div_top;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_acc;
  logic [WIDTH-1:0]     div_q, div_r;

  // Datapath: operand magnitudes, one multiply step, one restoring-divide step.
  always_comb begin
    signed_op = ~op_i[0];
    mag_a = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;

    pp = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (opb_q[j]) pp = pp + (mcand_q << j);
    end
    mul_acc      = acc_q + pp;
    mcand_shift  = mcand_q << MUL_BITS;
    mplier_shift = opb_q >> MUL_BITS;
    mul_res      = neg_p_q ? -mul_acc : mul_acc;
`ifdef MULDIV_EARLY_TERM_EN
    mul_last = (cnt_q == '0) || (mplier_shift == '0);
`else
    mul_last = (cnt_q == '0);
`endif

    // Shift the next dividend bit into the partial remainder and try a subtract.
    div_top = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = (div_top >= {1'b0, opb_q});
    div_rem = div_ge ? (div_top[WIDTH-1:0] - opb_q) : div_top[WIDTH-1:0];
    div_acc = {div_rem, acc_q[WIDTH-2:0], div_ge};
    div_q   = neg_p_q ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
    div_r   = neg_r_q ? -div_acc[2*WIDTH-1:WIDTH] : div_acc[2*WIDTH-1:WIDTH];
  end

  // Next-state and register-update logic; cancel overrides everything but reset.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    valid_d  = 1'b0;
    dbz_d    = dbz_q;

    if (cancel_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            is_div_d = op_i[1];
            neg_p_d  = signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r_d  = signed_op & a_i[WIDTH-1];
            opb_d    = mag_b;
            if (op_i[1] && (b_i == '0)) begin
              state_d = DONE;
              hi_d    = a_i;
              lo_d    = '1;
              dbz_d   = 1'b1;
              valid_d = 1'b1;
            end else if (op_i[1]) begin
              state_d = CALC;
              cnt_d   = DIV_LAST;
              acc_d   = {{WIDTH{1'b0}}, mag_a};
            end else begin
              state_d = CALC;
              cnt_d   = MUL_LAST;
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, mag_a};
            end
          end
        end
        CALC: begin
          cnt_d = cnt_q - 1'b1;
          if (is_div_q) begin
            acc_d = div_acc;
            if (cnt_q == '0) begin
              state_d = DONE;
              valid_d = 1'b1;
              dbz_d   = 1'b0;
              hi_d    = div_r;
              lo_d    = div_q;
            end
          end else begin
            acc_d   = mul_acc;
            mcand_d = mcand_shift;
            opb_d   = mplier_shift;
            if (mul_last) begin
              state_d = DONE;
              valid_d = 1'b1;
              dbz_d   = 1'b0;
              hi_d    = mul_res[2*WIDTH-1:WIDTH];
              lo_d    = mul_res[WIDTH-1:0];
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
      dbz_q    <= dbz_d;
    end
  end

  assign stall_o = ((state_q == IDLE) && start_i && !cancel_i) || (state_q == CALC);
  assign valid_o = valid_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign dbz_o   = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// Testbench for muldiv_iter: two instances (MUL_BITS=2 and MUL_BITS=1) sharing
// operands, checked against an arithmetic reference model.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, cancel = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        stall0, valid0, dbz0, stall1, valid1, dbz1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32), .MUL_BITS(2)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .op_i(op), .a_i(a), .b_i(b),
    .cancel_i(cancel), .stall_o(stall0), .valid_o(valid0), .hi_o(hi0),
    .lo_o(lo0), .dbz_o(dbz0)
  );

  muldiv_iter #(.WIDTH(32), .MUL_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .op_i(op), .a_i(a), .b_i(b),
    .cancel_i(cancel), .stall_o(stall1), .valid_o(valid1), .hi_o(hi1),
    .lo_o(lo1), .dbz_o(dbz1)
  );

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, y,
                                    output logic [31:0] rhi, rlo, output logic rdbz);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rdbz = 1'b0;
    p = 64'd0;
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) begin
          p = {x, 32'hFFFF_FFFF}; rdbz = 1'b1;
        end else begin
          q = sx / sy; r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) begin
          p = {x, 32'hFFFF_FFFF}; rdbz = 1'b1;
        end else begin
          p = {x % y, x / y};
        end
      end
    endcase
    rhi = p[63:32];
    rlo = p[31:0];
  endfunction

  // Expected cycles from start acceptance to the valid pulse.
  function automatic int exp_lat(input bit sel, input logic [1:0] o, input logic [31:0] y);
    int m, n, nb;
    logic [31:0] mb;
    m = sel ? 1 : 2;
    if (o[1]) return (y == 32'd0) ? 1 : 33;
    mb = ((o == 2'd0) && y[31]) ? -y : y;
    nb = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) nb = i + 1;
`ifdef MULDIV_EARLY_TERM_EN
    n = (nb + m - 1) / m;
    if (n < 1) n = 1;
`else
    n = 32 / m;
`endif
    return n + 1;
  endfunction

  // Drives one request (start held until stall drops) and reports what came back.
  task automatic run_op(input bit sel, input logic [1:0] o, input logic [31:0] x, y,
                        output logic [31:0] rhi, rlo, output logic rdbz,
                        output int lat, output bit stall_bad);
    bit done;
    @(negedge clk);
    op = o; a = x; b = y; cancel = 1'b0;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    #1;
    stall_bad = !(sel ? stall1 : stall0);
    lat = -1; done = 1'b0; rhi = '0; rlo = '0; rdbz = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      if (sel ? valid1 : valid0) begin
        lat = k; done = 1'b1;
        rhi = sel ? hi1 : hi0;
        rlo = sel ? lo1 : lo0;
        rdbz = sel ? dbz1 : dbz0;
        if (sel ? stall1 : stall0) stall_bad = 1'b1;
      end else if (!(sel ? stall1 : stall0)) begin
        stall_bad = 1'b1;
      end
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (hi0 !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi0); end
    checks++; if (lo0 !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall0); end
    checks++; if (dbz0 !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", dbz0); end
    checks++; if ({hi1, lo1} !== 64'd0) begin errors++; $display("FAIL reset_hilo1 got %h exp 0", {hi1, lo1}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]  ops [8];
    logic [31:0] as [8];
    logic [31:0] bs [8];
    logic [31:0] ghi, glo, ehi, elo;
    logic gdbz, edbz;
    int lat; bit sb;
    ops = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3};
    as  = '{32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h64, 32'h8000_0000,
            32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFFF};
    bs  = '{32'd6, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd1};
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, ops[i], as[i], bs[i], ghi, glo, gdbz, lat, sb);
      ref_model(ops[i], as[i], bs[i], ehi, elo, edbz);
      checks++; if ({ghi, glo} !== {ehi, elo}) begin errors++;
        $display("FAIL dir%0d_hilo op %0d got %h exp %h", i, ops[i], {ghi, glo}, {ehi, elo}); end
      checks++; if (gdbz !== edbz) begin errors++;
        $display("FAIL dir%0d_dbz got %b exp %b", i, gdbz, edbz); end
      checks++; if (lat != exp_lat(1'b0, ops[i], bs[i])) begin errors++;
        $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, exp_lat(1'b0, ops[i], bs[i])); end
      checks++; if (sb) begin errors++; $display("FAIL dir%0d_stall got bad exp clean", i); end
    end
  endtask

  task automatic test_cancel;
    logic [31:0] ghi, glo;
    logic gdbz; int lat; bit sb, seen;
    run_op(1'b0, 2'd1, 32'd7, 32'd6, ghi, glo, gdbz, lat, sb);
    checks++; if (glo !== 32'd42) begin errors++; $display("FAIL cancel_prior got %h exp 2a", glo); end
    @(negedge clk);
    op = 2'd3; a = 32'd100; b = 32'd7; start0 = 1'b1;   // cycle T
    repeat (4) @(negedge clk);
    @(negedge clk);                                     // cycle T+5
    start0 = 1'b0; cancel = 1'b1;
    @(negedge clk);                                     // cycle T+6
    cancel = 1'b0;
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL cancel_stall got %b exp 0", stall0); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (valid0) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL cancel_valid got 1 exp 0"); end
    checks++; if ({hi0, lo0} !== {32'd0, 32'd42}) begin errors++;
      $display("FAIL cancel_hold got %h exp %h", {hi0, lo0}, {32'd0, 32'd42}); end
    run_op(1'b0, 2'd1, 32'd2, 32'd3, ghi, glo, gdbz, lat, sb);
    checks++; if ({ghi, glo} !== 64'd6) begin errors++; $display("FAIL cancel_after got %h exp 6", {ghi, glo}); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    @(negedge clk);
    op = 2'd2; a = 32'd1000; b = 32'd3; start0 = 1'b1;  // cycle T
    repeat (9) @(negedge clk);
    @(negedge clk);                                     // cycle T+10
    rst = 1'b0; start0 = 1'b0;
    @(negedge clk);
    checks++; if ({hi0, lo0} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo got %h exp 0", {hi0, lo0}); end
    checks++; if (valid0 !== 1'b0 || stall0 !== 1'b0) begin errors++;
      $display("FAIL rstmid_ctl got v%b s%b exp v0 s0", valid0, stall0); end
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (valid0) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_valid got 1 exp 0"); end
  endtask

  task automatic test_back_to_back(input bit sel, input int n);
    logic [1:0]  o;
    logic [31:0] x, y, ghi, glo, ehi, elo;
    logic gdbz, edbz; int lat, mode; bit sb;
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom; y = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) y = 32'd0;
      else if (mode == 1) y = 32'($urandom_range(1, 15));
      else if (mode == 2) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (mode == 3) y = y >> $urandom_range(1, 31);
      run_op(sel, o, x, y, ghi, glo, gdbz, lat, sb);
      ref_model(o, x, y, ehi, elo, edbz);
      checks++; if ({ghi, glo} !== {ehi, elo}) begin errors++;
        $display("FAIL rnd%0d_%0d_hilo op %0d a %h b %h got %h exp %h", sel, i, o, x, y, {ghi, glo}, {ehi, elo}); end
      checks++; if (gdbz !== edbz) begin errors++;
        $display("FAIL rnd%0d_%0d_dbz got %b exp %b", sel, i, gdbz, edbz); end
      checks++; if (lat != exp_lat(sel, o, y)) begin errors++;
        $display("FAIL rnd%0d_%0d_latency got %0d exp %0d", sel, i, lat, exp_lat(sel, o, y)); end
      checks++; if (sb) begin errors++; $display("FAIL rnd%0d_%0d_stall got bad exp clean", sel, i); end
    end
  endtask

  task automatic test_mul_bits1;
    logic [31:0] ghi, glo;
    logic gdbz; int lat; bit sb;
    run_op(1'b1, 2'd1, 32'd3, 32'd5, ghi, glo, gdbz, lat, sb);
    checks++; if ({ghi, glo} !== 64'hF) begin errors++; $display("FAIL mb1_value got %h exp f", {ghi, glo}); end
`ifdef MULDIV_EARLY_TERM_EN
    checks++; if (lat != 4) begin errors++; $display("FAIL mb1_latency got %0d exp 4", lat); end
`else
    checks++; if (lat != 33) begin errors++; $display("FAIL mb1_latency got %0d exp 33", lat); end
`endif
    test_back_to_back(1'b1, 10);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cancel();
    test_reset_mid();
    test_back_to_back(1'b0, 30);
    test_mul_bits1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the execute stage. Successor to the fixed single-mode mul/div path.
- Handles signed and unsigned MULT and DIV at configurable width, with a configurable number of multiplier bits retired per cycle.
- Drives a combinational stall to the hazard unit while busy. Takes the hazard unit's flush as a cancel input.
- Result is a {hi, lo} pair that the pipeline forwards toward the HI/LO register.

Parameters:
- WIDTH, 32, operand width; hi_o and lo_o are each WIDTH bits.
- MUL_BITS, 2, multiplier bits retired per CALC cycle. WIDTH % MUL_BITS must be 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- start_i  input  1  request; held high by the E-stage instruction until stall_o drops.
- op_i  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a_i  input  WIDTH  multiplicand / dividend.
- b_i  input  WIDTH  multiplier / divisor.
- cancel_i  input  1  flush; abandons any operation in progress.
- stall_o  output  1  combinational; high while a result is pending.
- valid_o  output  1  one-cycle pulse when the result is ready.
- hi_o  output  WIDTH  product upper half, or remainder.
- lo_o  output  WIDTH  product lower half, or quotient.
- dbz_o  output  1  divide-by-zero flag, qualified by valid_o.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst=0 at a clock edge): state=IDLE, hi_o=0, lo_o=0, valid_o=0, dbz_o=0, iteration counter=0.
- stall_o = (state==IDLE & start_i & ~cancel_i) | (state==CALC).
- IDLE + start_i + ~cancel_i: latch op_i and operand magnitudes (two's-complement absolute value for signed ops). Record the result signs: quotient/product sign = a^b, remainder sign = sign of a.
  - DIV/DIVU with b_i==0 goes directly to DONE.
  - Otherwise go to CALC with the counter loaded.
- CALC, multiply: WIDTH/MUL_BITS cycles of radix-2^MUL_BITS shift-add on a 2*WIDTH accumulator.
- CALC, divide: WIDTH cycles of restoring division, one quotient bit per cycle.
- Last CALC cycle: apply sign correction and register hi_o/lo_o; next state DONE.
- DONE: valid_o=1 and stall_o=0, so the instruction leaves E. Always go to IDLE next, even if start_i is high.
  - hi_o/lo_o hold until the next result is registered.
- Latency: start accepted at cycle T; valid_o at T+N+1.
  - N = WIDTH/MUL_BITS for multiply.
  - N = WIDTH for divide.
  - N = 0 for divide-by-zero.
- Divide by zero: lo_o = all ones, hi_o = a_i, dbz_o=1.
- Signed overflow (MIN/-1): lo_o = MIN, hi_o = 0. No flag; this falls out of magnitude arithmetic.
- Signed division truncates toward zero. Remainder takes the sign of the dividend.
- cancel_i:
  - Highest priority after reset; wins over start_i in the same cycle.
  - In CALC or DONE: next state IDLE, valid_o=0 next cycle, hi_o/lo_o not updated, no valid pulse ever emitted for the cancelled op.
- Reset asserted mid-CALC: same as a power-on reset. No partial result is visible.
- Back-to-back operations: a new start_i is accepted in the IDLE cycle following DONE.

Optional Feature:
- Macro MULDIV_EARLY_TERM_EN.
- Defined: for MULT/MULTU, CALC ends after the iteration in which the remaining (not yet consumed) multiplier magnitude becomes zero.
  - Multiply N = max(1, ceil((msb_index(|b|)+1)/MUL_BITS)).
  - b==0 multiplies take N=1.
  - Division latency is unchanged.
- Undefined: fixed latency as in Behaviour. The zero-detect logic is absent.

Test Plan:
- MULTU, a=7, b=6, WIDTH=32, MUL_BITS=2, start at T -> stall_o high T..T+16, valid_o pulse at T+17, hi_o=0x00000000, lo_o=0x0000002A.
- MULT, a=0xFFFFFFFD (-3), b=5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. DIV, a=0xFFFFFFF9 (-7), b=2 -> valid_o at T+33, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU, a=0x64, b=0 -> valid_o at T+1, lo_o=0xFFFFFFFF, hi_o=0x00000064, dbz_o=1. DIV, a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU 100/7 started at T, cancel_i=1 at T+5 -> IDLE at T+6, no valid_o pulse, hi_o/lo_o keep prior values. Then MULTU 2*3 -> lo_o=6.
- rst=0 at T+10 during a DIV -> next cycle: state IDLE, hi_o=lo_o=0, valid_o=0, stall_o=0 with start_i low.
- MULTU a=3, b=5, MUL_BITS=1:
  - With MULDIV_EARLY_TERM_EN -> valid_o at T+4, lo_o=0xF.
  - Without -> valid_o at T+33, lo_o=0xF.
